// File: rtl/vga_plot_arbiter.sv
// Round-robin arbiter for the VGA adapter pixel-plot port: two pixel requesters plus a
// built-in full-frame clear sequencer that preempts both.
module vga_plot_arbiter #(
    parameter int unsigned XW   = 8,
    parameter int unsigned YW   = 7,
    parameter int unsigned CW   = 3,
    parameter int unsigned XMAX = 159,
    parameter int unsigned YMAX = 119
) (
    input  logic          CLOCK_50,
    input  logic          resetn,
    input  logic          clear_req,
    input  logic [CW-1:0] clear_color,
    output logic          clear_busy,
    input  logic          req0,
    input  logic [XW-1:0] x0,
    input  logic [YW-1:0] y0,
    input  logic [CW-1:0] c0,
    output logic          ack0,
    input  logic          req1,
    input  logic [XW-1:0] x1,
    input  logic [YW-1:0] y1,
    input  logic [CW-1:0] c1,
    output logic          ack1,
    output logic [XW-1:0] VGA_X,
    output logic [YW-1:0] VGA_Y,
    output logic [CW-1:0] VGA_COLOR,
    output logic          plot
);

    localparam logic [XW-1:0] XLast = XW'(XMAX);
    localparam logic [YW-1:0] YLast = YW'(YMAX);

    typedef enum logic [0:0] {StIdle, StClear} state_e;

    state_e        state_q, state_d;
    logic [XW-1:0] cx_q, cx_d, cx_nxt;
    logic [YW-1:0] cy_q, cy_d, cy_nxt;
    logic [CW-1:0] ccol_q, ccol_d;
    logic          last_q, last_d;

    logic [XW-1:0] vga_x_d;
    logic [YW-1:0] vga_y_d;
    logic [CW-1:0] vga_c_d;
    logic          plot_d, ack0_d, ack1_d, busy_d;

    logic          elig0, elig1, grant0, grant1;

    // A requester is not eligible during its own ack cycle, so a pixel is never plotted twice.
    assign elig0  = req0 & ~ack0;
    assign elig1  = req1 & ~ack1;
    assign grant0 = elig0 & (~elig1 | last_q);
    assign grant1 = elig1 & (~elig0 | ~last_q);

    // cx/cy hold the clear pixel currently on the outputs; cx_nxt/cy_nxt is the one after it.
    always_comb begin
        cx_nxt = cx_q + XW'(1);
        cy_nxt = cy_q;
        if (cx_q == XLast) begin
            cx_nxt = '0;
            cy_nxt = cy_q + YW'(1);
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                // A one-pixel frame finishes on the entry plot itself.
                if (clear_req && !(XLast == '0 && YLast == '0)) begin
                    state_d = StClear;
                end
            end
            StClear: begin
                if (cx_nxt == XLast && cy_nxt == YLast) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        vga_x_d = VGA_X;
        vga_y_d = VGA_Y;
        vga_c_d = VGA_COLOR;
        plot_d  = 1'b0;
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
        busy_d  = 1'b0;
        cx_d    = cx_q;
        cy_d    = cy_q;
        ccol_d  = ccol_q;
        last_d  = last_q;
        unique case (state_q)
            StIdle: begin
                if (clear_req) begin
                    ccol_d  = clear_color;
                    cx_d    = '0;
                    cy_d    = '0;
                    vga_x_d = '0;
                    vga_y_d = '0;
                    vga_c_d = clear_color;
                    plot_d  = 1'b1;
                    busy_d  = 1'b1;
                end else if (grant0) begin
                    vga_x_d = x0;
                    vga_y_d = y0;
                    vga_c_d = c0;
                    plot_d  = 1'b1;
                    ack0_d  = 1'b1;
                    last_d  = 1'b0;
                end else if (grant1) begin
                    vga_x_d = x1;
                    vga_y_d = y1;
                    vga_c_d = c1;
                    plot_d  = 1'b1;
                    ack1_d  = 1'b1;
                    last_d  = 1'b1;
                end
            end
            StClear: begin
                cx_d    = cx_nxt;
                cy_d    = cy_nxt;
                vga_x_d = cx_nxt;
                vga_y_d = cy_nxt;
                vga_c_d = ccol_q;
                plot_d  = 1'b1;
                busy_d  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            VGA_X      <= '0;
            VGA_Y      <= '0;
            VGA_COLOR  <= '0;
            plot       <= 1'b0;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            clear_busy <= 1'b0;
            cx_q       <= '0;
            cy_q       <= '0;
            ccol_q     <= '0;
            last_q     <= 1'b1;
        end else begin
            VGA_X      <= vga_x_d;
            VGA_Y      <= vga_y_d;
            VGA_COLOR  <= vga_c_d;
            plot       <= plot_d;
            ack0       <= ack0_d;
            ack1       <= ack1_d;
            clear_busy <= busy_d;
            cx_q       <= cx_d;
            cy_q       <= cy_d;
            ccol_q     <= ccol_d;
            last_q     <= last_d;
        end
    end

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Directed bench for vga_plot_arbiter: reset, single requester, round-robin, clear sweeps.
module tb_vga_plot_arbiter;

    localparam int XN = 160;
    localparam int YN = 120;
    localparam int FRAME = XN * YN;

    logic       CLOCK_50 = 1'b0;
    logic       resetn = 1'b0;
    logic       clear_req = 1'b0;
    logic [2:0] clear_color = '0;
    logic       clear_busy;
    logic       req0 = 1'b0, req1 = 1'b0;
    logic [7:0] x0 = '0, x1 = '0;
    logic [6:0] y0 = '0, y1 = '0;
    logic [2:0] c0 = '0, c1 = '0;
    logic       ack0, ack1;
    logic [7:0] VGA_X;
    logic [6:0] VGA_Y;
    logic [2:0] VGA_COLOR;
    logic       plot;

    int errors = 0;
    int checks = 0;

    vga_plot_arbiter dut (
        .CLOCK_50   (CLOCK_50),
        .resetn     (resetn),
        .clear_req  (clear_req),
        .clear_color(clear_color),
        .clear_busy (clear_busy),
        .req0       (req0),
        .x0         (x0),
        .y0         (y0),
        .c0         (c0),
        .ack0       (ack0),
        .req1       (req1),
        .x1         (x1),
        .y1         (y1),
        .c1         (c1),
        .ack1       (ack1),
        .VGA_X      (VGA_X),
        .VGA_Y      (VGA_Y),
        .VGA_COLOR  (VGA_COLOR),
        .plot       (plot)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    // Entered one step after the edge that sampled clear_req; walks the sweep until
    // clear_busy falls (or stop_at plots), checking row-major order and colour.
    task automatic sweep(input int col, input bit inject, input int stop_at,
                         output int plots, output int busy_cyc, output int bad,
                         output int acks, output int lx, output int ly);
        plots = 0; busy_cyc = 0; bad = 0; acks = 0; lx = -1; ly = -1;
        for (int n = 0; n < FRAME + 100; n++) begin
            if (!clear_busy) break;
            busy_cyc++;
            acks += int'(ack0) + int'(ack1);
            if (plot) begin
                if (int'(VGA_X) != plots % XN || int'(VGA_Y) != plots / XN ||
                    int'(VGA_COLOR) != col) bad++;
                lx = int'(VGA_X);
                ly = int'(VGA_Y);
                plots++;
            end else begin
                bad++;
            end
            if (stop_at != 0 && plots == stop_at) return;
            if (inject && plots == 500) begin
                clear_req   = 1'b1;
                clear_color = 3'd2;
            end else begin
                clear_req = 1'b0;
            end
            tick();
        end
        clear_req = 1'b0;
    endtask

    initial begin
        int got1, plots, busy_cyc, bad, acks, lx, ly, cnt;

        // Reset held with inputs toggling
        for (int i = 0; i < 4; i++) begin
            clear_req = 1'($urandom); clear_color = 3'($urandom);
            req0 = 1'($urandom); x0 = 8'($urandom); y0 = 7'($urandom); c0 = 3'($urandom);
            req1 = 1'($urandom); x1 = 8'($urandom); y1 = 7'($urandom); c1 = 3'($urandom);
            tick();
            check("rst_outs", int'({plot, ack0, ack1, clear_busy, VGA_X, VGA_Y, VGA_COLOR}), 0);
        end
        clear_req = 1'b0; req1 = 1'b0;
        req0 = 1'b1; x0 = 8'd5; y0 = 7'd6; c0 = 3'd3;
        resetn = 1'b1;
        tick();
        check("first_plot", int'(plot), 1);
        check("first_ack0", int'(ack0), 1);
        check("first_ack1", int'(ack1), 0);
        check("first_x", int'(VGA_X), 5);
        check("first_y", int'(VGA_Y), 6);
        check("first_c", int'(VGA_COLOR), 3);
        req0 = 1'b0;
        tick();
        check("idle_plot", int'(plot), 0);

        // Single requester held high, next pixel presented after each ack
        got1 = 0;
        req1 = 1'b1; x1 = 8'd10; y1 = 7'd20; c1 = 3'd1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("single_plot", int'(plot), int'(i % 2 == 0));
            check("single_ack1", int'(ack1), int'(i % 2 == 0));
            if (ack1) begin
                check("single_pix", int'(VGA_X), 10 + got1);
                got1++;
                x1 = 8'(10 + got1);
            end
        end
        req1 = 1'b0;
        check("single_count", got1, 3);
        tick();

        // Round-robin after a fresh reset: first tie goes to requester 0
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        req0 = 1'b1; x0 = 8'd30; y0 = 7'd31; c0 = 3'd2;
        req1 = 1'b1; x1 = 8'd40; y1 = 7'd41; c1 = 3'd4;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("rr_plot", int'(plot), 1);
            check("rr_ack0", int'(ack0), int'(i % 2 == 0));
            check("rr_ack1", int'(ack1), int'(i % 2 == 1));
            check("rr_x", int'(VGA_X), (i % 2 == 0) ? 30 : 40);
        end
        req0 = 1'b0; req1 = 1'b0;
        tick();

        // Full clear sweep
        clear_req = 1'b1; clear_color = 3'd5;
        tick();
        clear_req = 1'b0;
        check("clr_first_plot", int'(plot), 1);
        check("clr_first_busy", int'(clear_busy), 1);
        check("clr_first_xy", int'({VGA_X, VGA_Y}), 0);
        sweep(5, 1'b0, 0, plots, busy_cyc, bad, acks, lx, ly);
        check("clr_plots", plots, FRAME);
        check("clr_busy_cycles", busy_cyc, FRAME);
        check("clr_order_bad", bad, 0);
        check("clr_last_x", lx, XN - 1);
        check("clr_last_y", ly, YN - 1);
        check("clr_acks", acks, 0);
        check("clr_after_plot", int'(plot), 0);

        // Clear preempts pending requests; a second clear_req mid-sweep is ignored
        req0 = 1'b1; x0 = 8'd50; y0 = 7'd51; c0 = 3'd6;
        req1 = 1'b1; x1 = 8'd60; y1 = 7'd61; c1 = 3'd7;
        clear_req = 1'b1; clear_color = 3'd5;
        tick();
        clear_req = 1'b0;
        check("pre_busy", int'(clear_busy), 1);
        check("pre_acks0", int'({ack0, ack1}), 0);
        sweep(5, 1'b1, 0, plots, busy_cyc, bad, acks, lx, ly);
        check("pre_plots", plots, FRAME);
        check("pre_order_bad", bad, 0);
        check("pre_acks", acks, 0);
        check("pre_resume_plot", int'(plot), 1);
        check("pre_resume_ack0", int'(ack0), 1);
        check("pre_resume_x", int'(VGA_X), 50);
        req0 = 1'b0; req1 = 1'b0;
        tick();
        tick();

        // Reset in the middle of a sweep
        clear_req = 1'b1; clear_color = 3'd5;
        tick();
        clear_req = 1'b0;
        sweep(5, 1'b0, 1000, plots, busy_cyc, bad, acks, lx, ly);
        check("mid_plots", plots, 1000);
        resetn = 1'b0;
        #1;
        check("mid_rst_plot", int'(plot), 0);
        check("mid_rst_busy", int'(clear_busy), 0);
        check("mid_rst_x", int'(VGA_X), 0);
        tick();
        resetn = 1'b1;
        cnt = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            cnt += int'(plot) + int'(clear_busy);
        end
        check("mid_no_resume", cnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
